// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage (master) and instruction memory (slave). A request is
//               held on req/addr until valid returns the word in rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        req;    // request outstanding, address stable while high
  logic [31:0] addr;   // word-aligned request address
  logic [31:0] rdata;  // instruction word returned by memory
  logic        valid;  // rdata valid, completes the outstanding request

  // Fetch stage side: drives the request, consumes the response.
  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  // Memory side: consumes the request, drives the response.
  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Owns the PC, issues one
//               instruction-memory request at a time over a variable-latency
//               req/valid bus, and presents InstrF/PCF/PCPlus4F/ValidF to the
//               IF/ID register. Handles hazard stalls and Execute-stage
//               redirects, including redirects with a request in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  input  wire logic        StallF,
  input  wire logic        RedirectE,
  input  wire logic [31:0] PCTargetE,
  fetch_unit_if.master     imem,
  output logic      [31:0] InstrF,
  output logic      [31:0] PCF,
  output logic      [31:0] PCPlus4F,
  output logic             ValidF
);

  // S_IDLE : one settling cycle after reset, no request yet
  // S_REQ  : request on the bus, waiting for the matching response
  // S_DROP : redirected while a request was in flight; swallow its response
  // S_OUT  : buffered instruction presented to IF/ID
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_buf;
  logic [31:0] w_buf_next;
  logic [31:0] w_target;
  logic        unused_target_lsbs;

  // Redirect targets are forced to word alignment; the low bits carry no
  // information for the fetch stage.
  assign w_target           = {PCTargetE[31:2], 2'b00};
  assign unused_target_lsbs = ^PCTargetE[1:0];

  // State, PC and instruction buffer; reset is asynchronous so an in-flight
  // request is abandoned immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_buf   <= w_buf_next;
    end
  end

  // Next-state, next-PC and buffer capture. A redirect always wins over a
  // stall, and any response that belongs to a redirected-away PC is dropped.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_buf_next   = r_buf;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
      end

      S_REQ: begin
        if (RedirectE) begin
          w_pc_next = w_target;
          // If the response lands in the same cycle it is simply ignored and
          // the new address goes out next cycle; otherwise it is still in
          // flight and must be drained before a new request can issue.
          w_state_next = imem.valid ? S_REQ : S_DROP;
        end else if (imem.valid) begin
          w_buf_next   = imem.rdata;
          w_state_next = S_OUT;
        end
      end

      S_DROP: begin
        if (RedirectE) begin
          w_pc_next = w_target;
        end
        if (imem.valid) begin
          w_state_next = S_REQ;
        end
      end

      S_OUT: begin
        if (RedirectE) begin
          w_pc_next    = w_target;
          w_state_next = S_REQ;
        end else if (!StallF) begin
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bus and IF/ID outputs are pure decodes of the registered state, so
  // nothing on the memory side loops back combinationally.
  always_comb begin
    imem.req = (r_state == S_REQ);
    imem.addr = r_pc;
    ValidF    = (r_state == S_OUT);
    InstrF    = (r_state == S_OUT) ? r_buf : NOP_INSTR;
    PCF       = r_pc;
    PCPlus4F  = r_pc + 32'd4;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized self-checking bench for fetch_unit. A transaction
//               level memory with random latency answers requests, hazard
//               inputs are randomized, and a reference model tracks the
//               architectural PC, which response is live and when an
//               instruction should be on display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] C_NOP       = 32'h0000_0013;
  localparam int          C_STEPS     = 4000;

  logic        CLK;
  logic        RST;
  logic        StallF;
  logic        RedirectE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (C_RESET_PC),
    .NOP_INSTR (C_NOP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .StallF    (StallF),
    .RedirectE (RedirectE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .ValidF    (ValidF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Single comparison point: counts and reports a mismatch.
  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %08h expected %08h", tag, $time, got, exp);
    end
  endtask

  // Memory contents: a bijection of the address, so a stale word can never
  // masquerade as the right one.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1357};
  endfunction

  // Reference model state
  logic [31:0] exp_pc;
  bit          exp_req;
  bit          exp_valid;
  bit          idle;
  // Memory model state
  bit          mem_busy;
  bit          mem_stale;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_req"},    32'(bus.req), 32'd0);
    check_value({tag, "_valid"},  32'(ValidF), 32'd0);
    check_value({tag, "_instr"},  InstrF, C_NOP);
    check_value({tag, "_pcf"},    PCF, C_RESET_PC);
    check_value({tag, "_pcplus4"}, PCPlus4F, C_RESET_PC + 32'd4);
  endtask

  task automatic model_reset();
    exp_pc    = C_RESET_PC;
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    idle      = 1'b1;
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    mem_cnt   = 0;
    mem_addr  = '0;
  endtask

  initial begin
    bit          deliver;
    bit          deliver_stale;
    bit          stall;
    bit          redir;
    bit          next_valid;
    bit          did_mid_rst;
    logic [31:0] tgt;

    RST       = 1'b1;
    StallF    = 1'b0;
    RedirectE = 1'b0;
    PCTargetE = '0;
    bus.valid = 1'b0;
    bus.rdata = '0;
    did_mid_rst = 1'b0;

    // Reset takes effect before any clock edge.
    #2 RST = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    model_reset();

    for (int step = 0; step < C_STEPS; step++) begin
      // Observe the cycle that follows the previous rising edge.
      check_value("req",     32'(bus.req), 32'(exp_req));
      if (exp_req) check_value("addr", bus.addr, exp_pc);
      check_value("validf",  32'(ValidF), 32'(exp_valid));
      check_value("pcf",     PCF, exp_pc);
      check_value("pcplus4", PCPlus4F, exp_pc + 32'd4);
      check_value("instr",   InstrF, exp_valid ? mem_word(exp_pc) : C_NOP);

      // Asynchronous reset while a request is on the bus.
      if (step >= C_STEPS / 2 && !did_mid_rst && bus.req) begin
        #1 RST = 1'b0;
        #1 check_reset_outputs("midrst");
        bus.valid = 1'b0;
        StallF    = 1'b0;
        RedirectE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        did_mid_rst = 1'b1;
        continue;
      end

      // Memory: one transaction at a time, random latency 1..4 cycles.
      deliver       = 1'b0;
      deliver_stale = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          deliver       = 1'b1;
          deliver_stale = mem_stale;
          mem_busy      = 1'b0;
        end
      end else if (bus.req) begin
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_addr  = bus.addr;
        mem_cnt   = int'($urandom_range(1, 4));
      end
      bus.valid = deliver;
      bus.rdata = deliver ? mem_word(mem_addr) : $urandom;

      // Hazard inputs.
      stall = ($urandom_range(0, 2) == 0);
      redir = !idle && ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       tgt = 32'h0000_0203;
        1:       tgt = 32'hFFFF_FFFC;
        2:       tgt = 32'hFFFF_FFF9;
        default: tgt = $urandom;
      endcase
      StallF    = stall;
      RedirectE = redir;
      PCTargetE = tgt;

      // Reference model for the coming edge.
      if (redir && mem_busy) mem_stale = 1'b1;
      next_valid = !idle &&
                   ((deliver && !deliver_stale && !redir) ||
                    (exp_valid && stall && !redir));
      if (redir)                      exp_pc = {tgt[31:2], 2'b00};
      else if (exp_valid && !stall)   exp_pc = exp_pc + 32'd4;
      exp_valid = next_valid;
      exp_req   = !exp_valid && !(mem_busy && mem_stale);
      idle      = 1'b0;

      @(negedge CLK);
    end

    if (!did_mid_rst) begin
      n_cmp++;
      n_err++;
      $display("FAIL midrst_reached: got 0 expected 1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I pipeline.
- Owns the program counter and issues requests to instruction memory over a req/valid interface with variable latency.
- Presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register; EN on that register is driven from ~StallF, and FLUSH from RedirectE.
- Handles stalls from the hazard unit and redirects from branches/jumps resolved in Execute, including redirects that occur while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, value driven on InstrF while ValidF=0 (addi x0,x0,0).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous active-low reset.
- StallF  input  1  hazard unit: hold the current fetch output.
- RedirectE  input  1  branch/jump taken in Execute.
- PCTargetE  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- IMemReq  output  1  request to instruction memory.
- IMemAddr  output  32  request address, word aligned.
- IMemRdata  input  32  instruction returned by memory.
- IMemValid  input  1  IMemRdata valid; completes the outstanding request.
- InstrF  output  32  fetched instruction to IF/ID.
- PCF  output  32  PC of InstrF.
- PCPlus4F  output  32  PCF+4 to IF/ID.
- ValidF  output  1  InstrF/PCF hold a real fetched instruction.

Behaviour:
- Reset (RST=0, asynchronous):
  - State is S_IDLE, PC=RESET_PC, instruction buffer=NOP_INSTR.
  - Outputs: IMemReq=0, ValidF=0, InstrF=NOP_INSTR, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
  - Reset asserted mid-request abandons the request; memory is expected to be reset with the core.
- Memory protocol:
  - At most one outstanding request.
  - IMemReq is high and IMemAddr=PC is stable in every S_REQ cycle until IMemValid is seen.
  - IMemValid is sampled only while a request is outstanding (S_REQ or S_DROP). Earliest response is one cycle after IMemReq first rises; no combinational response.
- States (IMemReq is high only in S_REQ; ValidF is high only in S_OUT):
  - S_IDLE: next cycle go to S_REQ unconditionally. The first request therefore appears in the second clock after reset release.
  - S_REQ:
    - IMemValid=1 and RedirectE=0: buffer <= IMemRdata, go to S_OUT.
    - RedirectE=1 and IMemValid=1: discard the data, PC <= {PCTargetE[31:2],2'b00}, stay in S_REQ. The new address appears next cycle as a new request.
    - RedirectE=1 and IMemValid=0: PC <= target, go to S_DROP.
    - StallF has no effect in S_REQ.
  - S_DROP:
    - IMemReq=0; waiting for the stale response.
    - On IMemValid: discard the data, go to S_REQ.
    - A further RedirectE here overwrites PC again and keeps the state in S_DROP, or goes to S_REQ if IMemValid arrives in the same cycle.
  - S_OUT:
    - Outputs: ValidF=1, InstrF=buffer, PCF=PC.
    - RedirectE=1: PC <= target, go to S_REQ. Redirect has priority over StallF.
    - StallF=1: hold state, PC and buffer unchanged.
    - Otherwise: PC <= PC+4, go to S_REQ.
- Output drive when ValidF=0: InstrF=NOP_INSTR, PCF=PC.
- Arithmetic: PCPlus4F = PCF+4 modulo 2^32 in all states. PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Throughput: one instruction per 2+L cycles, where L is memory latency in cycles (L >= 1). No prefetch.

Test Plan:
- Reset release, memory latency 1:
  - IMemReq rises in cycle 2 with IMemAddr=0x0. IMemValid in cycle 3 with Rdata=0x00500093.
  - Cycle 4: ValidF=1, InstrF=0x00500093, PCF=0x0, PCPlus4F=0x4.
  - Cycle 5: IMemAddr=0x4.
- Stall: hold StallF=1 for 3 cycles during S_OUT.
  - ValidF, InstrF and PCF stay constant for those 3 cycles; no IMemReq.
  - After release, the next IMemAddr is PCF+4.
- Redirect in S_OUT with StallF=1 at PC=0x10, PCTargetE=0x203:
  - Next cycle IMemAddr=0x200; redirect overrides stall.
- Redirect during outstanding request (latency 4) at PC=0x8, target 0x40:
  - IMemReq drops for the remaining wait; the 0x8 response is not presented.
  - The next request is to 0x40; ValidF first shows PCF=0x40.
- Redirect in the same cycle as IMemValid:
  - The data is discarded; the next cycle requests the target; ValidF stays 0 until the target's data returns.
- Wrap and reset mid-request:
  - Fetch at PC=0xFFFFFFFC gives PCPlus4F=0x0, and the next request is to 0x0.
  - Asserting RST while IMemReq=1 gives IMemReq=0, ValidF=0 and PCF=RESET_PC immediately, without waiting for a clock edge.
